// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB first, odd parity, stop, device ack.
// Optional macro PS2_HOST_TX_RETRY_EN resends the latched byte up to twice after a NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  ps2_clk_in,
  input  logic                  ps2_data_in,
  output logic                  ps2_clk_drive_low,
  output logic                  ps2_data_drive_low,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_ok,
  output logic                  error
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = DATA_WIDTH + 1;
  localparam logic [3:0]    ACK_EDGE = 4'(DATA_WIDTH + 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, INHIBIT, SEND, WAIT_IDLE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      bit_q, bit_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic            ddl_q, ddl_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            dat_s1_q, dat_s2_q;
  logic            clk_fall;
  logic            fail_c;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]      try_q, try_d;
`endif

  // Pad synchronisers; idle-high reset so no spurious edge after reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      inh_q   <= '0;
      tmo_q   <= '0;
      bit_q   <= '0;
      ddl_q   <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      bit_q   <= bit_d;
      ddl_q   <= ddl_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
    frame_q <= frame_d;
    sh_q    <= sh_d;
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clk) begin
    if (rstn) try_q <= 2'd0;
    else      try_q <= try_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    sh_d    = sh_q;
    ddl_d   = ddl_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    err_d   = err_q;
    fail_c  = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    try_d   = try_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          frame_d = {~^tx_data, tx_data};
          err_d   = 1'b0;
          ack_d   = 1'b0;
          inh_d   = '0;
          state_d = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          try_d   = 2'd0;
`endif
        end
      end
      INHIBIT: begin
        inh_d = inh_q + IW'(1);
        if (inh_q == INH_LAST) begin
          ddl_d   = 1'b1;
          sh_d    = frame_q;
          bit_d   = '0;
          tmo_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TMO_LAST) begin
          fail_c = 1'b1;
        end else if (clk_fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == ACK_EDGE) begin
            ack_d   = ~dat_s2_q;
            state_d = WAIT_IDLE;
          end else begin
            // Ones shift in behind parity, so the tenth edge releases data as the stop bit.
            ddl_d = ~sh_q[0];
            sh_d  = {1'b1, sh_q[FW-1:1]};
          end
        end
      end
      WAIT_IDLE: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TMO_LAST) begin
          fail_c = 1'b1;
        end else if (clk_s2_q && dat_s2_q) begin
          if (ack_q) begin
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            fail_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail_c) begin
      ddl_d = 1'b0;
      ack_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (try_q != 2'd2) begin
        try_d   = try_q + 2'd1;
        inh_d   = '0;
        state_d = INHIBIT;
      end else begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
`else
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = IDLE;
`endif
    end
  end

  assign tx_ready           = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign ps2_clk_drive_low  = (state_q == INHIBIT);
  assign ps2_data_drive_low = ddl_q;
  assign done               = done_q;
  assign ack_ok             = ack_q;
  assign error              = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 200;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       busy, done, ack_ok, error;
  logic       dev_clk, dev_data;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  int         len, c, d0;
  bit         st, seen;
  logic [9:0] bits;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy), .done(done), .ack_ok(ack_ok), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic inhibit_phase(input bit spam, output int n, output bit start);
    int w = 0;
    while (!ps2_clk_drive_low && w < 100) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (ps2_clk_drive_low && n < 1000) begin
      if (spam) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    start = ps2_data_drive_low;
  endtask

  task automatic dev_frame(input bit nack, output logic [9:0] b);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      repeat (6) @(negedge clk);
      b[k] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
    dev_data = nack;
    dev_clk  = 1'b0;
    repeat (6) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic wait_done(output bit s);
    s = 1'b0;
    for (int i = 0; i < 100 && !s; i++) begin
      @(negedge clk);
      if (done) s = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    chk("rst_clk_dl", ps2_clk_drive_low, 0);
    chk("rst_data_dl", ps2_data_drive_low, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", ack_ok, 0);
    chk("rst_err", error, 0);

    req(8'hA5);
    repeat (5) @(negedge clk);
    chk("inh_busy", busy, 1);
    chk("inh_clk_dl", ps2_clk_drive_low, 1);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("mid_rst_clk_dl", ps2_clk_drive_low, 0);
    chk("mid_rst_data_dl", ps2_data_drive_low, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", busy, 0);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1
    req(8'hED);
    inhibit_phase(1'b0, len, st);
    chk("ed_inh_len", len, INH);
    chk("ed_start", st, 1);
    dev_frame(1'b0, bits);
    chk("ed_byte", bits[7:0], 8'hED);
    chk("ed_parity", bits[8], 1);
    chk("ed_stop", bits[9], 1);
    wait_done(seen);
    chk("ed_done", seen, 1);
    chk("ed_ack", ack_ok, 1);
    chk("ed_err", error, 0);
    @(negedge clk);
    chk("ed_pulse", done, 0);
    chk("ed_ready", tx_ready, 1);
    chk("ed_clk_rel", ps2_clk_drive_low, 0);
    chk("ed_data_rel", ps2_data_drive_low, 0);

    // 0xFF: NACK on every attempt except the last retry (when enabled)
    d0 = done_cnt;
    req(8'hFF);
    for (int a = 0; a < ATTEMPTS; a++) begin
      inhibit_phase(1'b0, len, st);
      chk("ff_inh_len", len, INH);
      chk("ff_start", st, 1);
      dev_frame((ATTEMPTS == 1) || (a < ATTEMPTS - 1), bits);
      chk("ff_byte", bits[7:0], 8'hFF);
      chk("ff_parity", bits[8], 1);
    end
    wait_done(seen);
    chk("ff_done", seen, 1);
`ifdef PS2_HOST_TX_RETRY_EN
    chk("ff_ack", ack_ok, 1);
    chk("ff_err", error, 0);
`else
    chk("ff_ack", ack_ok, 0);
    chk("ff_err", error, 1);
`endif
    chk("ff_busy_end", busy, 0);
    @(posedge clk);
    chk("ff_single_done", done_cnt - d0, 1);

    // 0xF4: bits 0,0,1,0,1,1,1,1, parity 0; tx_valid held during INHIBIT
    req(8'hF4);
    chk("f4_err_clr", error, 0);
    inhibit_phase(1'b1, len, st);
    chk("f4_inh_len", len, INH);
    chk("f4_start", st, 1);
    dev_frame(1'b0, bits);
    chk("f4_byte", bits[7:0], 8'hF4);
    chk("f4_parity", bits[8], 0);
    chk("f4_stop", bits[9], 1);
    wait_done(seen);
    chk("f4_done", seen, 1);
    chk("f4_ack", ack_ok, 1);
    chk("f4_err", error, 0);
    repeat (5) @(negedge clk);
    chk("f4_no_requeue", busy, 0);
    chk("f4_clk_idle", ps2_clk_drive_low, 0);

    // 0x55 with a silent device: timeout 200 cycles after clock release
    req(8'h55);
    for (int a = 0; a < ATTEMPTS; a++) begin
      inhibit_phase(1'b0, len, st);
      chk("to_inh_len", len, INH);
      c = 0;
      while (!done && !ps2_clk_drive_low && c < 400) begin
        @(negedge clk);
        c++;
      end
      chk("to_latency", c, TMO);
      chk("to_data_rel", ps2_data_drive_low, 0);
      chk("to_done", done, (a == ATTEMPTS - 1) ? 1 : 0);
    end
    chk("to_ack", ack_ok, 0);
    chk("to_err", error, 1);
    chk("to_clk_rel", ps2_clk_drive_low, 0);
    @(negedge clk);
    chk("to_idle", tx_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the shared ps2_clk/ps2_data open-drain lines.
- Sits beside the existing PS/2 scan-code receiver on the same pins.
- Drives the lines through active-low enables only; the pad tristates them, and the top level uses busy to hold the receiver off during a transfer.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from clock release to ack completion (20 ms at 50 MHz).
- DATA_WIDTH, 8: command byte width; only 8 is supported.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, synchronous, active-high despite the codebase port name.
- tx_data  input  8  command byte.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high only in IDLE; a byte is accepted when tx_valid&tx_ready.
- ps2_clk_in  input  1  sampled PS/2 clock pad.
- ps2_data_in  input  1  sampled PS/2 data pad.
- ps2_clk_drive_low  output  1  1 pulls ps2_clk low, 0 releases it.
- ps2_data_drive_low  output  1  1 pulls ps2_data low, 0 releases it.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a transfer ends (success or failure).
- ack_ok  output  1  valid with done: 1 = device acked, 0 = NACK or timeout.
- error  output  1  sticky failure flag; cleared by the next accepted byte or by reset.

Behaviour:
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 FFs (reset value 1). A falling edge is previous synced clk = 1 and current synced clk = 0, giving 3 cycles of detection latency.
- Reset values: drive_low outputs 0, tx_ready 1, busy 0, done 0, ack_ok 0, error 0, state IDLE. Reset mid-transfer releases both lines on the reset edge.
- Accept: latch tx_data into the shift register and compute parity = ~^tx_data (odd parity). Clear error and go to INHIBIT.
- INHIBIT: clk_drive_low=1 for exactly INHIBIT_CYCLES cycles. On the last of these cycles, set data_drive_low=1 (start bit) and go to RELEASE.
- RELEASE: clk_drive_low=0, data stays low, bit counter=0, timeout counter starts.
- SEND: on each falling edge of ps2_clk, present the next bit.
  - Edges 1-8 present data bits LSB first.
  - Edge 9 presents parity.
  - Edge 10 presents stop (data_drive_low=0).
  - A bit value of 1 means data_drive_low=0.
- ACK: on falling edge 11, sample synced data. ack_ok = (data==0).
- WAIT_IDLE: wait until synced clk and data are both 1. Then pulse done for 1 cycle, set error = ~ack_ok, and return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in any state from RELEASE onward:
  - release both lines;
  - done=1, ack_ok=0, error=1;
  - go to IDLE.
  - Timeout takes priority over a simultaneous edge.
- tx_valid is ignored while busy; no queueing.
- Line-state invariant: ps2_clk_drive_low is never 1 outside INHIBIT.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined: on NACK or timeout, the same latched byte is resent from INHIBIT, up to 2 extra attempts.
  - done and error assert only after success or after the 3rd failure.
  - busy stays high throughout.
- Undefined: the first failure terminates the transfer as described in Behaviour.

Test Plan:
- Reset mid-INHIBIT (rstn=1 for 1 cycle) -> both drive_low=0, tx_ready=1, busy=0 on the next cycle.
- Send 0xED, model device clocks at 80 us period and acks -> clock low for INHIBIT_CYCLES, start=0, bits 1,0,1,1,0,1,1,1, parity 1, stop released. done pulse with ack_ok=1, error=0.
- Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0. tx_valid pulses during busy are ignored.
- Device NACK (data high at edge 11) on 0xFF, macro off -> done, ack_ok=0, error=1. Next accepted byte clears error.
- Device never clocks, TIMEOUT_CYCLES=200 in sim -> lines released and done/error exactly 200 cycles after clock release.
- Macro on, device NACKs twice then acks -> 3 INHIBIT phases, a single done with ack_ok=1, error=0.
